// File: rtl/barrett_modmul_seq_if.sv
// Operand/result handshake bundle for the sequential Barrett modular multiplier.
// master = operand producer + result consumer, slave = the multiplier.
interface barrett_modmul_seq_if #(
  parameter int WIDTH = 64,
  parameter int KW    = $clog2(WIDTH) + 1
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic [KW-1:0]    k;
  logic [WIDTH:0]   mu;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] t;
  logic             err;

  modport master (
    output in_valid, a, b, q, k, mu, out_ready,
    input  in_ready, out_valid, t, err
  );

  modport slave (
    input  in_valid, a, b, q, k, mu, out_ready,
    output in_ready, out_valid, t, err
  );
endinterface

// File: rtl/barrett_modmul_seq.sv
// Multi-cycle t = (a*b) mod q via Barrett reduction with caller-supplied mu/k.
// One (WIDTH+1)x(WIDTH+1) multiplier is time-shared across x=a*b, q1*mu, q3*q;
// two unconditional correction stages keep latency fixed at 5 cycles.
module barrett_modmul_seq #(
  parameter int WIDTH = 64,
  parameter int KW    = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  barrett_modmul_seq_if.slave   bus
);
  localparam int PW = 2*WIDTH + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_MUL_X  = 3'd1;
  localparam logic [2:0] S_MUL_MU = 3'd2;
  localparam logic [2:0] S_MUL_Q  = 3'd3;
  localparam logic [2:0] S_CORR1  = 3'd4;
  localparam logic [2:0] S_CORR2  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]         state;
  logic [WIDTH-1:0]   a_r, b_r, q_r;
  logic [KW-1:0]      k_r;
  logic [WIDTH:0]     mu_r;
  logic [2*WIDTH-1:0] x_r;
  logic [PW-1:0]      q2_r;
  logic [2*WIDTH:0]   r_r;
  logic [WIDTH-1:0]   t_r;
  logic               err_r;

  logic [KW-1:0]      sh1, sh2;
  logic [2*WIDTH-1:0] x_sh;
  logic [PW-1:0]      q2_sh;
  logic [WIDTH:0]     q1, q3;
  logic [WIDTH:0]     mul_a, mul_b;
  logic [PW-1:0]      prod;
  logic [2*WIDTH:0]   q_ext, r_corr;
  logic               err_flag;
  logic               unused_bits;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.t         = t_r;
  assign bus.err       = err_r;

  // Barrett shifts; shift amounts wrap harmlessly on illegal k (result is masked by err)
  always_comb begin
    sh1   = k_r - KW'(1);
    sh2   = k_r + KW'(1);
    x_sh  = x_r >> sh1;
    q2_sh = q2_r >> sh2;
    q1    = x_sh[WIDTH:0];
    q3    = q2_sh[WIDTH:0];
  end

  assign unused_bits = ^{x_sh[2*WIDTH-1:WIDTH+1], q2_sh[PW-1:WIDTH+1]};

  // Operand mux for the single shared multiplier, selected by state
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      S_MUL_X:  begin mul_a = {1'b0, a_r}; mul_b = {1'b0, b_r}; end
      S_MUL_MU: begin mul_a = q1;          mul_b = mu_r;        end
      S_MUL_Q:  begin mul_a = q3;          mul_b = {1'b0, q_r}; end
      default:  ;
    endcase
  end

  assign prod = {{(WIDTH+1){1'b0}}, mul_a} * {{(WIDTH+1){1'b0}}, mul_b};

  // Conditional subtract shared by both correction stages; operand check on captured values
  always_comb begin
    q_ext    = {{(WIDTH+1){1'b0}}, q_r};
    r_corr   = (r_r >= q_ext) ? (r_r - q_ext) : r_r;
    err_flag = (q_r == '0) | (a_r >= q_r) | (b_r >= q_r) |
               (k_r < KW'(2)) | (k_r > KW'(WIDTH));
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      q_r   <= '0;
      k_r   <= '0;
      mu_r  <= '0;
      x_r   <= '0;
      q2_r  <= '0;
      r_r   <= '0;
      t_r   <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          a_r   <= bus.a;
          b_r   <= bus.b;
          q_r   <= bus.q;
          k_r   <= bus.k;
          mu_r  <= bus.mu;
          state <= S_MUL_X;
        end
        S_MUL_X: begin
          x_r   <= prod[2*WIDTH-1:0];
          state <= S_MUL_MU;
        end
        S_MUL_MU: begin
          q2_r  <= prod;
          state <= S_MUL_Q;
        end
        S_MUL_Q: begin
          r_r   <= {1'b0, x_r} - prod[2*WIDTH:0];
          state <= S_CORR1;
        end
        S_CORR1: begin
          r_r   <= r_corr;
          state <= S_CORR2;
        end
        S_CORR2: begin
          r_r   <= r_corr;
          t_r   <= err_flag ? '0 : r_corr[WIDTH-1:0];
          err_r <= err_flag;
          state <= S_DONE;
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_barrett_modmul_seq.sv
// Scoreboard bench for barrett_modmul_seq: expectations from a plain (a*b)%q model
// are queued at accept and popped when the result is presented.
module tb_barrett_modmul_seq;
  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] t;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;

  barrett_modmul_seq_if #(.WIDTH(W)) bus ();
  barrett_modmul_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] a, b, q, input logic [6:0] k);
    exp_t e;
    logic [127:0] p;
    logic [127:0] m;
    e.err = (q == 0) || (a >= q) || (b >= q) || (k < 2) || (k > W);
    p = {64'd0, a} * {64'd0, b};
    m = e.err ? 128'd0 : p % {64'd0, q};
    e.t = m[W-1:0];
    return e;
  endfunction

  // Present operands, wait (bounded) for acceptance, queue the model result
  task automatic send(input logic [W-1:0] a, b, q, input logic [6:0] k,
                      input logic [W:0] mu, output bit ok);
    bus.a = a; bus.b = b; bus.q = q; bus.k = k; bus.mu = mu;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !bus.in_ready; i++) tick();
    if (bus.in_ready) begin
      tick();
      ok = 1'b1;
      sb.push_back(model(a, b, q, k));
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total_cnt++;
      $display("FAIL send: in_ready stuck at 0, exp 1");
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.q = '0; bus.k = '0; bus.mu = '0;
    tick(); tick();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.t !== '0) $display("FAIL rst_t: got %0d exp 0", bus.t); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL rst_err: got %0b exp 0", bus.err); else pass_cnt++;
    rst = 1'b0;
    tick();
  endtask

  // Known-answer cases with out_ready tied high; check latency and release timing
  task automatic test_known();
    logic [W-1:0] ta[5], tb_[5], tq[5], tt[5];
    logic [6:0]   tk[5];
    logic [W:0]   tm[5];
    bit ok; int lat; exp_t e;
    ta[0] = 1467;    tb_[0] = 2489;    tq[0] = 7681; tk[0] = 13; tm[0] = 8736; tt[0] = 2888;
    ta[1] = 7680;    tb_[1] = 7680;    tq[1] = 7681; tk[1] = 13; tm[1] = 8736; tt[1] = 1;
    ta[2] = 0;       tb_[2] = 5;       tq[2] = 7681; tk[2] = 13; tm[2] = 8736; tt[2] = 0;
    ta[3] = 64'd1 << 60; tb_[3] = 4;   tq[3] = (64'd1 << 61) - 1; tk[3] = 61;
    tm[3] = (65'd1 << 61) + 1; tt[3] = 2;
    ta[4] = (64'd1 << 61) - 2; tb_[4] = (64'd1 << 61) - 2; tq[4] = (64'd1 << 61) - 1;
    tk[4] = 61; tm[4] = (65'd1 << 61) + 1; tt[4] = 1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb_[i], tq[i], tk[i], tm[i], ok);
      if (!ok) continue;
      wait_out(lat);
      total_cnt++; if (lat !== 5) $display("FAIL known%0d_latency: got %0d exp 5", i, lat); else pass_cnt++;
      e = sb.pop_front();
      total_cnt++; if (bus.t !== e.t) $display("FAIL known%0d_t_model: got %0d exp %0d", i, bus.t, e.t); else pass_cnt++;
      total_cnt++; if (bus.t !== tt[i]) $display("FAIL known%0d_t: got %0d exp %0d", i, bus.t, tt[i]); else pass_cnt++;
      total_cnt++; if (bus.err !== 1'b0) $display("FAIL known%0d_err: got %0b exp 0", i, bus.err); else pass_cnt++;
      total_cnt++; if (dut.r_r[2*W:W] !== '0) $display("FAIL known%0d_r_upper: got %0h exp 0", i, dut.r_r[2*W:W]); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL known%0d_ready_in_done: got %0b exp 0", i, bus.in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
        $display("FAIL known%0d_release: got ready=%0b valid=%0b exp ready=1 valid=0", i, bus.in_ready, bus.out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_err();
    logic [W-1:0] ea[3], eq[3];
    logic [6:0]   ek[3];
    bit ok; int lat; exp_t e;
    ea[0] = 7681; eq[0] = 7681; ek[0] = 13;
    ea[1] = 5;    eq[1] = 0;    ek[1] = 13;
    ea[2] = 5;    eq[2] = 7681; ek[2] = 1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ea[i], 64'd5, eq[i], ek[i], 65'd8736, ok);
      if (!ok) continue;
      wait_out(lat);
      e = sb.pop_front();
      total_cnt++; if (lat !== 5) $display("FAIL err%0d_latency: got %0d exp 5", i, lat); else pass_cnt++;
      total_cnt++; if (bus.err !== e.err || bus.err !== 1'b1) $display("FAIL err%0d_err: got %0b exp 1", i, bus.err); else pass_cnt++;
      total_cnt++; if (bus.t !== e.t) $display("FAIL err%0d_t: got %0d exp %0d", i, bus.t, e.t); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; exp_t e; bit stable;
    bus.out_ready = 1'b0;
    send(64'd1467, 64'd2489, 64'd7681, 7'd13, 65'd8736, ok);
    if (!ok) return;
    wait_out(lat);
    e = sb.pop_front();
    total_cnt++; if (lat !== 5) $display("FAIL bp_latency: got %0d exp 5", lat); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = i[0];
      bus.a = 64'd3; bus.b = 64'd4;
      tick();
      stable = bus.out_valid === 1'b1 && bus.in_ready === 1'b0 && bus.t === e.t && bus.err === 1'b0;
      total_cnt++;
      if (!stable) $display("FAIL bp_hold%0d: got valid=%0b ready=%0b t=%0d err=%0b exp valid=1 ready=0 t=%0d err=0",
                            i, bus.out_valid, bus.in_ready, bus.t, bus.err, e.t);
      else pass_cnt++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release: got valid=%0b ready=%0b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    else pass_cnt++;
    total_cnt++; if (bus.t !== 64'd2888) $display("FAIL bp_t_hold: got %0d exp 2888", bus.t); else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stable = 1'b0;
    end
    total_cnt++; if (!stable) $display("FAIL bp_stray_accept: got out_valid=1 exp 0"); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    bit ok; int lat; exp_t e; bit quiet;
    bus.out_ready = 1'b1;
    send(64'd1467, 64'd2489, 64'd7681, 7'd13, 65'd8736, ok);
    if (!ok) return;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_front());
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %0b exp 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %0b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.t !== '0) $display("FAIL midrst_t: got %0d exp 0", bus.t); else pass_cnt++;
    total_cnt++; if (bus.err !== 1'b0) $display("FAIL midrst_err: got %0b exp 0", bus.err); else pass_cnt++;
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) quiet = 1'b0;
    end
    total_cnt++; if (!quiet) $display("FAIL midrst_ghost: got out_valid=1 exp 0"); else pass_cnt++;
    send(64'd1467, 64'd2489, 64'd7681, 7'd13, 65'd8736, ok);
    if (!ok) return;
    wait_out(lat);
    e = sb.pop_front();
    total_cnt++; if (lat !== 5) $display("FAIL midrst_new_latency: got %0d exp 5", lat); else pass_cnt++;
    total_cnt++; if (bus.t !== e.t || bus.t !== 64'd2888) $display("FAIL midrst_new_t: got %0d exp 2888", bus.t); else pass_cnt++;
    tick();
  endtask

  // Random q of random bit length; k and mu derived here, compared against (a*b)%q
  task automatic test_sweep();
    logic [W-1:0] q, a, b;
    logic [6:0]   k;
    logic [129:0] num, quo;
    bit ok; int lat; exp_t e; int kk;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      kk = $urandom_range(2, W);
      q = {$urandom, $urandom};
      if (kk < W) q = q & ((64'd1 << kk) - 1);
      q[kk-1] = 1'b1;
      if (kk == W && q == (64'd1 << 63)) q[0] = 1'b1;
      k = 7'(kk);
      num = 130'd1 << (2*kk);
      quo = num / {66'd0, q};
      a = {$urandom, $urandom} % q;
      b = {$urandom, $urandom} % q;
      send(a, b, q, k, quo[W:0], ok);
      if (!ok) break;
      wait_out(lat);
      if (!bus.out_valid) begin
        total_cnt++;
        $display("FAIL sweep%0d_timeout: got out_valid=0 exp 1", n);
        break;
      end
      e = sb.pop_front();
      total_cnt++; if (bus.t !== e.t || bus.err !== e.err)
        $display("FAIL sweep%0d: a=%0d b=%0d q=%0d got t=%0d err=%0b exp t=%0d err=%0b",
                 n, a, b, q, bus.t, bus.err, e.t, e.err);
      else pass_cnt++;
      total_cnt++; if (dut.r_r[2*W:W] !== '0) $display("FAIL sweep%0d_r_upper: got %0h exp 0", n, dut.r_r[2*W:W]); else pass_cnt++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_known();
    test_err();
    test_backpressure();
    test_reset_midop();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
